serial_subtractor: RTL and testbench

- Bit-serial subtractor: computes diff = a - b - b_in, LSB first, one bit per clock, through a single borrow flip-flop.
- Inverse-direction companion to the combinational full-adder cell.
- Used as the low-area subtract element in CGRA processing elements; a ripple chain costs too much area there.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first,
// through a single borrow flop, with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;

  logic             a0, b0, d_bit, br_next;
  logic [WIDTH-1:0] a_shift;

  assign a0      = a_q[0];
  assign b0      = b_q[0];
  assign d_bit   = a0 ^ b0 ^ br_q;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  // The A register doubles as the result register: operand bits leave at
  // the LSB while difference bits enter at the MSB.
  assign a_shift = WIDTH'({d_bit, a_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = b_in;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_shift;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // d_bit is the last bit shifted in, i.e. the result MSB.
          diff_d  = a_shift;
          b_out_d = br_next;
          ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, backpressure
// and mid-run reset sequences at WIDTH=8, then random streams at WIDTH=1/8/16.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, b_in;
  logic         out_valid, out_ready, b_out, ovf;
  logic [W-1:0] a, b, diff;

  int total = 0;
  int bad   = 0;
  bit start_rand = 1'b0;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Presents operands at a falling edge, accepts on the next rising edge and
  // returns how many further rising edges pass until out_valid is seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, output int lat);
    @(negedge clk);
    chk("in_ready_before_op", in_ready, 1);
    a = ta; b = tb_v; b_in = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[9];

  // Random streams, one independent DUT per width.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int RW = (gi == 0) ? 1 : ((gi == 1) ? 8 : 16);
    logic          r_iv, r_ir, r_bin, r_ov, r_or, r_bo, r_of;
    logic [RW-1:0] r_a, r_b, r_d;
    logic          done_flag = 1'b0;

    serial_subtractor #(.WIDTH(RW)) u_rdut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (r_iv),
      .in_ready  (r_ir),
      .a         (r_a),
      .b         (r_b),
      .b_in      (r_bin),
      .out_valid (r_ov),
      .out_ready (r_or),
      .diff      (r_d),
      .b_out     (r_bo),
      .ovf       (r_of)
    );

    initial begin
      logic [RW-1:0] ea, eb;
      logic          ebin, seen, exp_ov;
      logic [RW:0]   full;
      int            cyc;
      r_iv = 1'b0; r_or = 1'b0; r_a = '0; r_b = '0; r_bin = 1'b0;
      wait (start_rand);
      for (int n = 0; n < 1000; n++) begin
        ea = RW'($urandom); eb = RW'($urandom); ebin = 1'($urandom);
        @(negedge clk);
        chk($sformatf("w%0d_in_ready", RW), r_ir, 1);
        r_a = ea; r_b = eb; r_bin = ebin; r_iv = 1'b1;
        @(posedge clk);
        #1 r_iv = 1'b0;
        full   = {1'b0, ea} - {1'b0, eb} - {{RW{1'b0}}, ebin};
        exp_ov = (ea[RW-1] ^ eb[RW-1]) & (full[RW-1] ^ ea[RW-1]);
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 200) begin
          @(negedge clk);
          r_or = ($urandom_range(0, 3) != 0);
          if (r_ov) begin
            if (!seen) begin
              chk($sformatf("w%0d_diff", RW), 32'(r_d), 32'(full[RW-1:0]));
              chk($sformatf("w%0d_b_out", RW), r_bo, full[RW]);
              chk($sformatf("w%0d_ovf", RW), r_of, exp_ov);
            end
            seen = 1'b1;
            if (r_or) break;
          end
          cyc++;
        end
        @(posedge clk);
        #1 r_or = 1'b0;
        if (cyc >= 200) begin
          chk($sformatf("w%0d_timeout", RW), 0, 1);
          break;
        end
      end
      done_flag = 1'b1;
    end
  end

  initial begin
    int  lat;
    bit  spur;
    bit  all_done;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h01, 8'h80, 1'b0, 8'h81, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_ovf", ovf, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      chk($sformatf("vec%0d_latency", i), lat, W);
      chk($sformatf("vec%0d_diff", i), diff, vecs[i].d);
      chk($sformatf("vec%0d_b_out", i), b_out, vecs[i].bo);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
      $display("op a=0x%02h b=0x%02h bin=%0d -> diff=0x%02h b_out=%0d ovf=%0d lat=%0d",
               vecs[i].a, vecs[i].b, vecs[i].bin, diff, b_out, ovf, lat);
      finish_op();
    end

    // Backpressure: new operands offered while the result is held must be ignored.
    run_op(8'h35, 8'h12, 1'b0, lat);
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; b_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", diff, 8'h23);
      chk("bp_b_out", b_out, 0);
      chk("bp_ovf", ovf, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    $display("op backpressure hold: diff=0x23 held 5 cycles");
    run_op(8'hAA, 8'h55, 1'b0, lat);
    chk("bp_next_latency", lat, W);
    chk("bp_next_diff", diff, 8'h55);
    chk("bp_next_b_out", b_out, 0);
    chk("bp_next_ovf", ovf, 1);
    $display("op a=0xaa b=0x55 bin=0 -> diff=0x%02h b_out=%0d ovf=%0d", diff, b_out, ovf);
    finish_op();

    // Reset during the third RUN cycle.
    @(negedge clk);
    a = 8'h5A; b = 8'h21; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    spur = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 spur = spur | out_valid;
    end
    chk("midrst_no_spurious_valid", spur, 0);
    run_op(8'h07, 8'h03, 1'b0, lat);
    chk("midrst_next_latency", lat, W);
    chk("midrst_next_diff", diff, 8'h04);
    chk("midrst_next_b_out", b_out, 0);
    $display("op after reset a=0x07 b=0x03 -> diff=0x%02h lat=%0d", diff, lat);
    finish_op();

    start_rand = 1'b1;
    all_done = 1'b0;
    for (int c = 0; c < 90000; c++) begin
      all_done = g_rand[0].done_flag && g_rand[1].done_flag && g_rand[2].done_flag;
      if (all_done) break;
      @(posedge clk);
    end
    chk("rand_complete", all_done, 1);
    $display("random streams finished for widths 1, 8, 16");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
